// File: rtl/uart_time_cmd_pkg.sv
// Shared definitions for the UART time-set command parser: state encoding,
// ASCII constants and BCD range limits.
package uart_time_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DIGITS    = 2'd1,
      ST_WAIT_TERM = 2'd2,
      ST_COMMIT    = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_T    = 8'h54;
   localparam logic [7:0] ASCII_CR   = 8'h0D;

   localparam logic [3:0] HOUR_TENS_MAX           = 4'd2;
   localparam logic [3:0] HOUR_UNITS_MAX_AT_TENS2 = 4'd3;
   localparam logic [3:0] MIN_TENS_MAX            = 4'd5;
   localparam logic [3:0] SEC_TENS_MAX            = 4'd5;

   localparam int unsigned NUM_DIGITS = 6;

   // Digit order: [0]=hour tens, [1]=hour units, [2]=min tens, [3]=min units,
   // [4]=sec tens, [5]=sec units.
   typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

   // True when the buffered digits form a legal 24-hour time.
   function automatic logic time_in_range(input digits_t d);
      logic hour_ok;
      hour_ok = (d[0] < HOUR_TENS_MAX) ||
                ((d[0] == HOUR_TENS_MAX) && (d[1] <= HOUR_UNITS_MAX_AT_TENS2));
      return hour_ok && (d[2] <= MIN_TENS_MAX) && (d[4] <= SEC_TENS_MAX);
   endfunction

endpackage

// File: rtl/uart_time_cmd_if.sv
// Byte-stream input and time/status outputs of the command parser.
interface uart_time_cmd_if;

   logic       i_rx_valid;
   logic [7:0] i_rx_data;
   logic [7:0] o_hour;
   logic [7:0] o_min;
   logic [7:0] o_sec;
   logic       o_load;
   logic       o_error;
   logic       o_busy;

   modport master (
      output i_rx_valid, i_rx_data,
      input  o_hour, o_min, o_sec, o_load, o_error, o_busy
   );

   modport slave (
      input  i_rx_valid, i_rx_data,
      output o_hour, o_min, o_sec, o_load, o_error, o_busy
   );

endinterface

// File: rtl/uart_time_cmd_ascii_digit_decode.sv
// Combinational ASCII decimal digit decoder.
module ascii_digit_decode
   import uart_time_cmd_pkg::*;
(
   input  logic [7:0] data,
   output logic [3:0] value,
   output logic       is_digit
);

   logic [7:0] offset;

   // Bytes below '0' wrap to large values, so one unsigned compare covers both ends.
   always_comb begin
      offset   = data - ASCII_ZERO;
      is_digit = (offset <= 8'd9);
      value    = offset[3:0];
   end

endmodule

// File: rtl/uart_time_cmd.sv
// UART time-set command parser: "<HDR>HHMMSS<TERM>" loads a BCD time.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | waiting for header byte, other bytes ignored
// ST_DIGITS    | collecting six ASCII digits into the shadow buffer
// ST_WAIT_TERM | six digits held, expecting terminator
// ST_COMMIT    | one cycle: outputs loaded, o_load high; acts as IDLE
module uart_time_cmd
   import uart_time_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0]  HDR_CHAR       = ASCII_T,
   parameter logic [7:0]  TERM_CHAR      = ASCII_CR
)(
   input logic            i_clk,
   input logic            i_rst_n,
   uart_time_cmd_if.slave bus
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [2:0]    LAST_IDX = 3'(NUM_DIGITS - 1);

   state_t        state;
   logic [2:0]    idx;
   logic [CW-1:0] cnt;
   digits_t       shadow;
   logic [7:0]    hour;
   logic [7:0]    min;
   logic [7:0]    sec;
   logic          load;
   logic          error;
   logic          busy;

   logic [3:0]    dig_val;
   logic          is_digit;

   ascii_digit_decode u_digit (
      .data     (bus.i_rx_data),
      .value    (dig_val),
      .is_digit (is_digit)
   );

   // Command FSM with inter-byte timeout; all outputs registered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= ST_IDLE;
         idx    <= '0;
         cnt    <= '0;
         shadow <= '0;
         hour   <= '0;
         min    <= '0;
         sec    <= '0;
         load   <= 1'b0;
         error  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         load  <= 1'b0;
         error <= 1'b0;
         if ((state == ST_DIGITS || state == ST_WAIT_TERM) && !bus.i_rx_valid) begin
            // A byte in the same cycle takes priority, so timeout only counts idle cycles.
            if (cnt >= CNT_LAST) begin
               error <= 1'b1;
               state <= ST_IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end else if (cnt != CNT_MAX) begin
               cnt <= cnt + CNT_ONE;
            end
         end else begin
            unique case (state)
               ST_IDLE, ST_COMMIT: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  if (bus.i_rx_valid && (bus.i_rx_data == HDR_CHAR)) begin
                     state <= ST_DIGITS;
                     idx   <= '0;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end
               end
               ST_DIGITS: begin
                  cnt <= '0;
                  if (is_digit) begin
                     shadow[idx] <= dig_val;
                     if (idx == LAST_IDX) begin
                        state <= ST_WAIT_TERM;
                     end else begin
                        idx <= idx + 3'd1;
                     end
                  end else if (bus.i_rx_data == HDR_CHAR) begin
                     idx <= '0;
                  end else begin
                     error <= 1'b1;
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
               ST_WAIT_TERM: begin
                  cnt <= '0;
                  if (bus.i_rx_data == TERM_CHAR) begin
                     busy <= 1'b0;
                     if (time_in_range(shadow)) begin
                        state <= ST_COMMIT;
                        load  <= 1'b1;
                        hour  <= {shadow[0], shadow[1]};
                        min   <= {shadow[2], shadow[3]};
                        sec   <= {shadow[4], shadow[5]};
                     end else begin
                        state <= ST_IDLE;
                        error <= 1'b1;
                     end
                  end else if (bus.i_rx_data == HDR_CHAR) begin
                     state <= ST_DIGITS;
                     idx   <= '0;
                  end else begin
                     state <= ST_IDLE;
                     error <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.o_hour  = hour;
   assign bus.o_min   = min;
   assign bus.o_sec   = sec;
   assign bus.o_load  = load;
   assign bus.o_error = error;
   assign bus.o_busy  = busy;

endmodule

// File: tb/tb_uart_time_cmd.sv
// Testbench for uart_time_cmd: directed command strings, a byte-level
// reference model and per-cycle comparison, plus literal spot checks.
module tb_uart_time_cmd;

   localparam int TO = 100;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   uart_time_cmd_if bus ();

   uart_time_cmd #(
      .TIMEOUT_CYCLES (TO),
      .HDR_CHAR       (8'h54),
      .TERM_CHAR      (8'h0D)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_vec  = 0;
   int n_bad  = 0;
   int n_load = 0;
   int n_err  = 0;
   bit chk_en = 1'b0;

   // Reference model state.
   bit         m_active = 1'b0;
   int         m_nd     = 0;
   int         m_idle   = 0;
   int         m_dig[6];
   int         m_h, m_m, m_s;
   logic [7:0] m_b;
   logic [7:0] exp_hour  = 8'h00;
   logic [7:0] exp_min   = 8'h00;
   logic [7:0] exp_sec   = 8'h00;
   logic       exp_load  = 1'b0;
   logic       exp_error = 1'b0;
   logic       exp_busy  = 1'b0;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Byte-level model: tracks the command text received since the header
   // and judges it as a whole time value when the terminator arrives.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active  = 1'b0;
         m_nd      = 0;
         m_idle    = 0;
         exp_hour  = 8'h00;
         exp_min   = 8'h00;
         exp_sec   = 8'h00;
         exp_load  = 1'b0;
         exp_error = 1'b0;
         exp_busy  = 1'b0;
      end else begin
         exp_load  = 1'b0;
         exp_error = 1'b0;
         if (bus.i_rx_valid) begin
            m_b    = bus.i_rx_data;
            m_idle = 0;
            if (!m_active) begin
               if (m_b == 8'h54) begin
                  m_active = 1'b1;
                  m_nd     = 0;
               end
            end else if (m_b == 8'h54) begin
               m_nd = 0;
            end else if (m_nd < 6) begin
               if (m_b >= 8'h30 && m_b <= 8'h39) begin
                  m_dig[m_nd] = int'(m_b) - 48;
                  m_nd++;
               end else begin
                  exp_error = 1'b1;
                  m_active  = 1'b0;
               end
            end else begin
               m_active = 1'b0;
               m_h = m_dig[0] * 10 + m_dig[1];
               m_m = m_dig[2] * 10 + m_dig[3];
               m_s = m_dig[4] * 10 + m_dig[5];
               if (m_b == 8'h0D && m_h <= 23 && m_m <= 59 && m_s <= 59) begin
                  exp_load = 1'b1;
                  exp_hour = to_bcd(m_h);
                  exp_min  = to_bcd(m_m);
                  exp_sec  = to_bcd(m_s);
               end else begin
                  exp_error = 1'b1;
               end
            end
         end else if (m_active) begin
            m_idle++;
            if (m_idle >= TO) begin
               exp_error = 1'b1;
               m_active  = 1'b0;
            end
         end
         exp_busy = m_active;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("hour",  bus.o_hour, exp_hour);
         check("min",   bus.o_min,  exp_min);
         check("sec",   bus.o_sec,  exp_sec);
         check("load",  8'(bus.o_load),  8'(exp_load));
         check("error", 8'(bus.o_error), 8'(exp_error));
         check("busy",  8'(bus.o_busy),  8'(exp_busy));
         check("load_error_exclusive", 8'(bus.o_load & bus.o_error), 8'h00);
         if (bus.o_load === 1'b1)  n_load++;
         if (bus.o_error === 1'b1) n_err++;
      end
   end

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         bus.i_rx_valid = 1'b1;
         bus.i_rx_data  = s[i];
         @(negedge clk);
      end
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      bus.i_rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_time(input string name, input logic [7:0] h,
                             input logic [7:0] m, input logic [7:0] s);
      check({name, "_hour"}, bus.o_hour, h);
      check({name, "_min"},  bus.o_min,  m);
      check({name, "_sec"},  bus.o_sec,  s);
   endtask

   int base_load;
   int base_err;

   initial begin
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'h00;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check_time("reset", 8'h00, 8'h00, 8'h00);
      check("reset_busy", 8'(bus.o_busy), 8'h00);
      rst_n = 1'b1;

      // Basic command, first byte on the first edge after release.
      base_load = n_load;
      send("T123456\015");
      check("s1_load_latency", 8'(bus.o_load), 8'h01);
      check_time("s1", 8'h12, 8'h34, 8'h56);
      idle(3);
      check("s1_load_count", 8'(n_load - base_load), 8'd1);

      // Hour 24 rejected, outputs untouched.
      base_load = n_load; base_err = n_err;
      send("T245959\015");
      idle(3);
      check("s2_err_count", 8'(n_err - base_err), 8'd1);
      check("s2_load_count", 8'(n_load - base_load), 8'd0);
      check_time("s2", 8'h12, 8'h34, 8'h56);

      // Stray bytes outside a command are ignored silently.
      base_err = n_err;
      send("X5\015");
      idle(2);
      check("s3_err_count", 8'(n_err - base_err), 8'd0);

      // Header inside digits restarts without error.
      base_err = n_err;
      send("T12T235959\015");
      idle(2);
      check("s4_err_count", 8'(n_err - base_err), 8'd0);
      check_time("s4", 8'h23, 8'h59, 8'h59);

      // Timeout after exactly TO idle cycles.
      base_err = n_err;
      send("T12");
      idle(TO - 1);
      check("s5_busy_before_to", 8'(bus.o_busy), 8'h01);
      idle(1);
      check("s5_to_pulse", 8'(bus.o_error), 8'h01);
      idle(5);
      check("s5_err_count", 8'(n_err - base_err), 8'd1);
      check("s5_busy_after", 8'(bus.o_busy), 8'h00);
      check_time("s5", 8'h23, 8'h59, 8'h59);

      // Byte arriving on the timeout cycle wins.
      base_err = n_err;
      send("T1");
      idle(TO - 1);
      send("23456\015");
      idle(2);
      check("s6_err_count", 8'(n_err - base_err), 8'd0);
      check_time("s6", 8'h12, 8'h34, 8'h56);

      // Range and framing rejects.
      base_err = n_err;
      send("T305959\015");
      send("T006000\015");
      send("T000060\015");
      send("T123456X");
      idle(2);
      check("s7_err_count", 8'(n_err - base_err), 8'd4);
      check_time("s7", 8'h12, 8'h34, 8'h56);
      send("T111111T230000\015");
      idle(2);
      check_time("s7b", 8'h23, 8'h00, 8'h00);

      // Reset mid-command.
      send("T0000");
      #2 rst_n = 1'b0;
      #1;
      check_time("s8_rst", 8'h00, 8'h00, 8'h00);
      check("s8_rst_busy", 8'(bus.o_busy), 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      base_load = n_load; base_err = n_err;
      idle(4);
      check("s8_quiet_load", 8'(n_load - base_load), 8'd0);
      check("s8_quiet_err", 8'(n_err - base_err), 8'd0);
      send("T000001\015");
      check("s8_load", 8'(bus.o_load), 8'h01);
      check_time("s8", 8'h00, 8'h00, 8'h01);
      idle(2);

      // Header during COMMIT starts the next command.
      base_load = n_load;
      send("T000000\015T010203\015");
      idle(3);
      check("s9_load_count", 8'(n_load - base_load), 8'd2);
      check_time("s9", 8'h01, 8'h02, 8'h03);

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
